// File: rtl/branch_target_buffer_pkg.sv
// rtl/branch_target_buffer_pkg.sv - address and BTB entry types shared by the fetch-unit BTB slice
package branch_target_buffer_pkg;

  localparam int ADDR_WIDTH = 32;
  typedef logic [ADDR_WIDTH-1:0] PC;

  localparam int BTB_ENTRY_NUM   = 64;
  localparam int BTB_INDEX_WIDTH = $clog2(BTB_ENTRY_NUM);
  localparam int BTB_TAG_WIDTH   = ADDR_WIDTH - BTB_INDEX_WIDTH - 2;

  typedef logic [BTB_INDEX_WIDTH-1:0] BtbIndex;
  typedef logic [BTB_TAG_WIDTH-1:0]   BtbTag;
  typedef logic [1:0]                 BranchCounter;

  typedef struct packed {
    logic         valid;
    BtbTag        tag;
    PC            target;
    BranchCounter ctr;
  } BtbEntry;

  localparam BranchCounter CTR_WEAKLY_TAKEN = 2'b10;

  // Instruction addresses are word aligned, so bits [1:0] never take part.
  function automatic BtbIndex toBtbIndex(PC addr);
    return addr[BTB_INDEX_WIDTH+1:2];
  endfunction

  function automatic BtbTag toBtbTag(PC addr);
    return addr[ADDR_WIDTH-1:BTB_INDEX_WIDTH+2];
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch lookup and execute-stage training signals of the BTB
interface branch_target_buffer_if;
  import branch_target_buffer_pkg::*;

  PC    pc;
  logic btbHit;
  PC    btbPredictedPc;
  logic isBranchTakenPredicted;

  logic updateEn;
  PC    updatePc;
  PC    updateTarget;
  logic updateTaken;

  modport master (
    output pc, updateEn, updatePc, updateTarget, updateTaken,
    input  btbHit, btbPredictedPc, isBranchTakenPredicted
  );

  modport slave (
    input  pc, updateEn, updatePc, updateTarget, updateTaken,
    output btbHit, btbPredictedPc, isBranchTakenPredicted
  );

endinterface

// File: rtl/branch_counter_update.sv
// rtl/branch_counter_update.sv - 2-bit saturating direction counter step (taken, ctr -> ctr')
module branch_counter_update
  import branch_target_buffer_pkg::*;
(
  input  logic         taken,
  input  BranchCounter ctr,
  output BranchCounter nextCtr
);

  always_comb begin
    nextCtr = ctr;
    if (taken) begin
      if (ctr != 2'b11) nextCtr = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) nextCtr = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB, combinational lookup, synchronous training.
// Optional BTB_UPDATE_BYPASS_EN forwards a same-cycle update of the looked-up entry to the outputs.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  branch_target_buffer_if.slave btb
);

  BtbEntry entries [BTB_ENTRY_NUM];

  BtbIndex      updIdx;
  BtbTag        updTag;
  BtbEntry      updOld;
  logic         updHit;
  BranchCounter stepCtr;
  BtbEntry      newEntry;
  logic         writeEn;

  assign updIdx = toBtbIndex(btb.updatePc);
  assign updTag = toBtbTag(btb.updatePc);
  assign updOld = entries[updIdx];
  assign updHit = updOld.valid && (updOld.tag == updTag);

  // One counter step serves both the write path and the lookup bypass.
  branch_counter_update counterStep (
    .taken   (btb.updateTaken),
    .ctr     (updOld.ctr),
    .nextCtr (stepCtr)
  );

  always_comb begin
    writeEn  = 1'b0;
    newEntry = updOld;
    if (btb.updateEn) begin
      if (updHit) begin
        writeEn      = 1'b1;
        newEntry.ctr = stepCtr;
        if (btb.updateTaken) newEntry.target = btb.updateTarget;
      end else if (btb.updateTaken) begin
        // Taken miss allocates, evicting whatever tag occupied the slot.
        writeEn         = 1'b1;
        newEntry.valid  = 1'b1;
        newEntry.tag    = updTag;
        newEntry.target = btb.updateTarget;
        newEntry.ctr    = CTR_WEAKLY_TAKEN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRY_NUM; i++) entries[i].valid <= 1'b0;
    end else if (writeEn) begin
      entries[updIdx] <= newEntry;
    end
  end

  BtbIndex lkIdx;
  BtbTag   lkTag;
  BtbEntry lkEntry;
  logic    lkHit;

  assign lkIdx = toBtbIndex(btb.pc);
  assign lkTag = toBtbTag(btb.pc);

`ifdef BTB_UPDATE_BYPASS_EN
  always_comb begin
    lkEntry = entries[lkIdx];
    if (writeEn && !rst && (lkIdx == updIdx) && (lkTag == updTag)) lkEntry = newEntry;
  end
`else
  assign lkEntry = entries[lkIdx];
`endif

  assign lkHit                      = lkEntry.valid && (lkEntry.tag == lkTag);
  assign btb.btbHit                 = lkHit;
  assign btb.btbPredictedPc         = lkHit ? lkEntry.target : '0;
  assign btb.isBranchTakenPredicted = lkHit && lkEntry.ctr[1];

endmodule
